dmem_lsu: RTL and testbench

- Load/store unit between the pipelined CPU's MEM stage and a multi-cycle data memory with a req/ready handshake.
- Turns the CPU's access (address, store data, 3-bit access type) into word-aligned memory transactions with byte enables.
- Sign- or zero-extends load data, detects misaligned accesses and bus timeouts.
- Raises a stall to the pipeline while a transaction is outstanding.

---
 rtl/dmem_lsu.sv | 221 ++++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit bridging the MEM stage to a req/ready data memory
module dmem_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_r,
  input  logic        cpu_mem_w,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_dmtype,
  output logic [31:0] cpu_rdata,
  output logic        lsu_stall,
  output logic        lsu_misalign,
  output logic        lsu_buserr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Last counter value before a bus error; unused when the timeout is disabled.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic             TO_EN   = (TIMEOUT_CYCLES != 0);

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic              buserr_q, buserr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        type_q, type_d;
  logic [1:0]        lo_q, lo_d;

  logic              access;
  logic              aligned;
  logic              start;
  logic              ready_hit;
  logic              timeout_hit;
  logic [3:0]        be_n;
  logic [31:0]       wdata_n;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;

  assign access      = cpu_mem_r | cpu_mem_w;
  assign start       = access & aligned;
  // A ready seen while no request is outstanding carries no meaning.
  assign ready_hit   = mem_ready & mem_req_q;
  assign timeout_hit = TO_EN & ~mem_ready & (cnt_q == TO_LAST);

  // Decode access type into alignment check, byte enables and lane-replicated store data.
  always_comb begin
    aligned = 1'b0;
    be_n    = 4'b0000;
    wdata_n = cpu_wdata;
    case (cpu_dmtype)
      3'b000: begin
        aligned = (cpu_addr[1:0] == 2'b00);
        be_n    = 4'b1111;
        wdata_n = cpu_wdata;
      end
      3'b001, 3'b010: begin
        aligned = ~cpu_addr[0];
        be_n    = cpu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{cpu_wdata[15:0]}};
      end
      3'b011, 3'b100: begin
        aligned = 1'b1;
        be_n    = 4'b0001 << cpu_addr[1:0];
        wdata_n = {4{cpu_wdata[7:0]}};
      end
      default: begin
        aligned = 1'b0;
        be_n    = 4'b0000;
      end
    endcase
  end

  // Pick the addressed lane of the returned word and extend it per the latched type.
  always_comb begin
    case (lo_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (type_q)
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_ext = {16'h0000, half_sel};
      3'b011:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  if (ready_hit || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: stall from the accepting IDLE cycle through BUSY; misalign only in IDLE.
  always_comb begin
    lsu_stall    = 1'b0;
    lsu_misalign = 1'b0;
    case (state_q)
      S_IDLE: begin
        lsu_stall    = start;
        lsu_misalign = access & ~aligned;
      end
      S_BUSY:  lsu_stall = 1'b1;
      default: begin
        lsu_stall    = 1'b0;
        lsu_misalign = 1'b0;
      end
    endcase
  end

  // Datapath next state: latch the transaction on accept, hold it through BUSY, close on ready or timeout.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    buserr_d    = 1'b0;
    cnt_d       = cnt_q;
    type_d      = type_q;
    lo_d        = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_mem_w;
          mem_addr_d  = {cpu_addr[31:2], 2'b00};
          mem_be_d    = be_n;
          mem_wdata_d = wdata_n;
          type_d      = cpu_dmtype;
          lo_d        = cpu_addr[1:0];
          cnt_d       = '0;
        end
      end
      S_BUSY: begin
        if (ready_hit) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) cpu_rdata_d = load_ext;
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          buserr_d  = 1'b1;
          if (!mem_we_q) cpu_rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      cpu_rdata_q <= 32'h0;
      buserr_q    <= 1'b0;
      cnt_q       <= '0;
      type_q      <= 3'b000;
      lo_q        <= 2'b00;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      buserr_q    <= buserr_d;
      cnt_q       <= cnt_d;
      type_q      <= type_d;
      lo_q        <= lo_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign lsu_buserr = buserr_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu
module tb_dmem_lsu;

  logic        clk;
  logic        reset;
  logic        cpu_mem_r;
  logic        cpu_mem_w;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_dmtype;
  logic [31:0] cpu_rdata;
  logic        lsu_stall;
  logic        lsu_misalign;
  logic        lsu_buserr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  dmem_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_mem_r    (cpu_mem_r),
    .cpu_mem_w    (cpu_mem_w),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_dmtype   (cpu_dmtype),
    .cpu_rdata    (cpu_rdata),
    .lsu_stall    (lsu_stall),
    .lsu_misalign (lsu_misalign),
    .lsu_buserr   (lsu_buserr),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_clear();
    cpu_mem_r  = 1'b0;
    cpu_mem_w  = 1'b0;
    cpu_addr   = 32'h0;
    cpu_wdata  = 32'h0;
    cpu_dmtype = 3'b000;
  endtask

  task automatic issue(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] t);
    cpu_mem_r  = r;
    cpu_mem_w  = w;
    cpu_addr   = a;
    cpu_wdata  = wd;
    cpu_dmtype = t;
  endtask

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    cpu_clear();
    repeat (3) tick();
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_buserr", lsu_buserr, 0);
    chk("rst_stall", lsu_stall, 0);
    reset = 1'b1;

    // 1: lw 0x100, ready on first BUSY cycle
    tick();
    issue(1, 0, 32'h100, 32'h0, 3'b000);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_idle_stall", lsu_stall, 1);
    chk("lw_idle_mis", lsu_misalign, 0);
    chk("lw_idle_req", mem_req, 0);
    tick();
    chk("lw_busy_req", mem_req, 1);
    chk("lw_busy_addr", mem_addr, 32'h100);
    chk("lw_busy_be", mem_be, 4'hF);
    chk("lw_busy_we", mem_we, 0);
    chk("lw_busy_stall", lsu_stall, 1);
    tick();
    cpu_clear();
    #1;
    chk("lw_done_stall", lsu_stall, 0);
    chk("lw_done_req", mem_req, 0);
    chk("lw_done_rdata", cpu_rdata, 32'hDEADBEEF);

    // 2: lb / lbu 0x103
    tick();
    issue(1, 0, 32'h103, 32'h0, 3'b011);
    mem_rdata = 32'h80FF1234;
    tick();
    chk("lb_be", mem_be, 4'b1000);
    chk("lb_addr", mem_addr, 32'h100);
    tick();
    cpu_clear();
    #1;
    chk("lb_rdata", cpu_rdata, 32'hFFFFFF80);
    tick();
    issue(1, 0, 32'h103, 32'h0, 3'b100);
    tick();
    tick();
    cpu_clear();
    #1;
    chk("lbu_rdata", cpu_rdata, 32'h00000080);

    // extra: lh 0x102 signed, lhu 0x100
    tick();
    issue(1, 0, 32'h102, 32'h0, 3'b001);
    mem_rdata = 32'h8001_7F02;
    tick();
    chk("lh_be", mem_be, 4'b1100);
    tick();
    cpu_clear();
    #1;
    chk("lh_rdata", cpu_rdata, 32'hFFFF8001);
    tick();
    issue(1, 0, 32'h100, 32'h0, 3'b010);
    mem_rdata = 32'h1234_F00D;
    tick();
    chk("lhu_be", mem_be, 4'b0011);
    tick();
    cpu_clear();
    #1;
    chk("lhu_rdata", cpu_rdata, 32'h0000F00D);

    // 3: sh 0x202 with 3 wait cycles
    tick();
    issue(0, 1, 32'h202, 32'h0000ABCD, 3'b001);
    mem_ready = 1'b0;
    #1;
    chk("sh_idle_stall", lsu_stall, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) mem_ready = 1'b1;
      #1;
      chk("sh_busy_req", mem_req, 1);
      chk("sh_busy_we", mem_we, 1);
      chk("sh_busy_be", mem_be, 4'b1100);
      chk("sh_busy_wdata", mem_wdata, 32'hABCDABCD);
      chk("sh_busy_addr", mem_addr, 32'h200);
      chk("sh_busy_stall", lsu_stall, 1);
    end
    tick();
    cpu_clear();
    #1;
    chk("sh_done_stall", lsu_stall, 0);
    chk("sh_done_req", mem_req, 0);
    chk("sh_rdata_kept", cpu_rdata, 32'h0000F00D);

    // byte store replication
    tick();
    issue(0, 1, 32'h301, 32'h000000A5, 3'b011);
    tick();
    chk("sb_be", mem_be, 4'b0010);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    tick();
    cpu_clear();

    // 4: misaligned lw 0x101 then lh 0x103, plus illegal type
    tick();
    issue(1, 0, 32'h101, 32'h0, 3'b000);
    #1;
    chk("mis_lw_flag", lsu_misalign, 1);
    chk("mis_lw_stall", lsu_stall, 0);
    tick();
    chk("mis_lw_req", mem_req, 0);
    issue(1, 0, 32'h103, 32'h0, 3'b001);
    #1;
    chk("mis_lh_flag", lsu_misalign, 1);
    chk("mis_lh_stall", lsu_stall, 0);
    tick();
    chk("mis_lh_req", mem_req, 0);
    issue(1, 0, 32'h100, 32'h0, 3'b101);
    #1;
    chk("mis_type_flag", lsu_misalign, 1);
    tick();
    chk("mis_type_req", mem_req, 0);
    chk("mis_rdata_kept", cpu_rdata, 32'h0000F00D);
    cpu_clear();

    // 5: timeout after 4 BUSY cycles
    tick();
    issue(1, 0, 32'h400, 32'h0, 3'b000);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_busy_req", mem_req, 1);
      chk("to_busy_err", lsu_buserr, 0);
    end
    tick();
    cpu_clear();
    #1;
    chk("to_done_req", mem_req, 0);
    chk("to_done_err", lsu_buserr, 1);
    chk("to_done_rdata", cpu_rdata, 0);
    chk("to_done_stall", lsu_stall, 0);
    tick();
    chk("to_idle_err", lsu_buserr, 0);
    chk("to_idle_req", mem_req, 0);

    // 6: reset during sw BUSY, then a fresh lw
    issue(0, 1, 32'h500, 32'h12345678, 3'b000);
    tick();
    chk("rs_busy_req", mem_req, 1);
    reset = 1'b0;
    cpu_clear();
    #1;
    chk("rs_req_drop", mem_req, 0);
    chk("rs_we_drop", mem_we, 0);
    chk("rs_stall", lsu_stall, 0);
    tick();
    reset = 1'b1;
    tick();
    issue(1, 0, 32'h104, 32'h0, 3'b000);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    #1;
    chk("rs_new_stall", lsu_stall, 1);
    tick();
    chk("rs_new_req", mem_req, 1);
    chk("rs_new_addr", mem_addr, 32'h104);
    tick();
    cpu_clear();
    #1;
    chk("rs_new_rdata", cpu_rdata, 32'hCAFEF00D);
    chk("rs_new_req_done", mem_req, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
